// File: rtl/ps2_pkg.sv
// Purpose: shared scan-code constants, event record and decoder state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERR1   = 8'hFF;

    // Pause is E1 followed by seven more bytes that carry no extra information
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam int EVT_W = 10;

    // Field order {brk, ext, code}
    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } evt_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } state_t;

    // Keyboard housekeeping bytes that never form part of a key event
    function automatic logic is_ctrl(input logic [7:0] b);
        return (b == SC_ACK) || (b == SC_BAT) || (b == SC_ECHO) ||
               (b == SC_RESEND) || (b == SC_ERR0) || (b == SC_ERR1);
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == SC_EXT) || (b == SC_BRK) || (b == SC_PAUSE);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Purpose: generic synchronous first-word-fall-through FIFO.
// Latency: written word is visible on dout one clock after push when empty.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module ps2_event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    output logic                         full,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array, no reset needed: contents are only read when non-empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Purpose: decode PS/2 set-2 byte stream (E0/F0/E1 prefixes) into key events.
// Latency: event on evt_* one clock after the completing byte (FIFO empty).
// Backpressure: evt_valid/evt_ready; events dropped with sticky overflow when full.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                              CLOCK_50,
    input  logic                              reset,
    input  logic [7:0]                        rx_data,
    input  logic                              rx_valid,
    output logic [7:0]                        evt_code,
    output logic                              evt_ext,
    output logic                              evt_break,
    output logic                              evt_valid,
    input  logic                              evt_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overflow,
    input  logic                              clr_overflow,
    output logic                              seq_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    state_t        state, state_nx;
    logic [2:0]    skip, skip_nx;
    logic [TW-1:0] tcnt;
    logic          tmo;
    logic          push;
    evt_t          push_evt;
    logic          err;

    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic [EVT_W-1:0] fifo_dout;
    evt_t          head;
    evt_t          hold;
    evt_t          shown;

    // Partial sequence abandoned when the line has been quiet too long
    assign tmo = (state != ST_IDLE) && !rx_valid &&
                 (tcnt == TW'(TIMEOUT_CYCLES - 1));

    // State, Pause skip count and idle-timeout counter
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            skip  <= '0;
            tcnt  <= '0;
        end else begin
            state <= state_nx;
            skip  <= skip_nx;
            if (rx_valid || state == ST_IDLE || tmo) tcnt <= '0;
            else                                     tcnt <= tcnt + TW'(1);
        end
    end

    // Sequence decode: next state, event push and malformed-sequence detection
    always_comb begin
        state_nx = state;
        skip_nx  = skip;
        push     = 1'b0;
        push_evt = '0;
        err      = 1'b0;
        if (rx_valid) begin
            case (state)
                ST_IDLE: begin
                    if (rx_data == SC_EXT)        state_nx = ST_EXT;
                    else if (rx_data == SC_BRK)   state_nx = ST_BRK;
                    else if (rx_data == SC_PAUSE) begin
                        state_nx = ST_PAUSE;
                        skip_nx  = PAUSE_SKIP;
                    end else if (!is_ctrl(rx_data)) begin
                        push     = 1'b1;
                        push_evt = '{brk: 1'b0, ext: 1'b0, code: rx_data};
                    end
                end
                ST_EXT: begin
                    if (rx_data == SC_BRK)      state_nx = ST_EXT_BRK;
                    else if (rx_data == SC_EXT) state_nx = ST_EXT;
                    else if (is_ctrl(rx_data) || rx_data == SC_PAUSE) begin
                        err      = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        push     = 1'b1;
                        push_evt = '{brk: 1'b0, ext: 1'b1, code: rx_data};
                        state_nx = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    state_nx = ST_IDLE;
                    if (is_prefix(rx_data) || is_ctrl(rx_data)) begin
                        err = 1'b1;
                    end else begin
                        push     = 1'b1;
                        push_evt = '{brk: 1'b1, ext: (state == ST_EXT_BRK),
                                     code: rx_data};
                    end
                end
                ST_PAUSE: begin
                    if (skip == 3'd1) begin
                        push     = 1'b1;
                        push_evt = '{brk: 1'b0, ext: 1'b1, code: SC_PAUSE};
                        state_nx = ST_IDLE;
                    end else begin
                        skip_nx = skip - 3'd1;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end else if (tmo) begin
            err      = 1'b1;
            state_nx = ST_IDLE;
        end
    end

    // Sticky overflow (set beats clear) and one-cycle error pulse
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            seq_error <= 1'b0;
        end else begin
            seq_error <= err;
            if (push && fifo_full && !pop) overflow <= 1'b1;
            else if (clr_overflow)         overflow <= 1'b0;
        end
    end

    assign pop = evt_valid && evt_ready;

    ps2_event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLOCK_50),
        .rst   (reset),
        .push  (push),
        .din   (push_evt),
        .full  (fifo_full),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head = evt_t'(fifo_dout);

    // Remember the last popped event so evt_* stay put once the FIFO drains
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)    hold <= '0;
        else if (pop) hold <= head;
    end

    assign shown     = fifo_empty ? hold : head;
    assign evt_valid = !fifo_empty;
    assign evt_code  = shown.code;
    assign evt_ext   = shown.ext;
    assign evt_break = shown.brk;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Purpose: self-checking bench for ps2_scancode_decoder (vector table + scoreboard).
// Latency: inputs driven 1 time unit after rising edge, outputs sampled on falling edge.
// Backpressure: evt_ready toggled to exercise full, overflow and simultaneous push/pop.
module tb_ps2_scancode_decoder;

    localparam int DEPTH = 8;
    localparam int TMO   = 200;
    localparam int CW    = $clog2(DEPTH+1);

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    evt_code;
    logic          evt_ext;
    logic          evt_break;
    logic          evt_valid;
    logic          evt_ready;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          clr_overflow;
    logic          seq_error;

    int errors = 0;
    int checks = 0;

    logic [9:0] sb [$];

    typedef struct {
        logic [7:0] b;
        bit         push;
        logic [9:0] evt;
        bit         err;
    } vec_t;

    vec_t vecs [$];

    ps2_scancode_decoder #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .evt_code     (evt_code),
        .evt_ext      (evt_ext),
        .evt_break    (evt_break),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .seq_error    (seq_error)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_v(input logic [7:0] b, input bit p, input logic [9:0] e, input bit er);
        vec_t v;
        v.b = b; v.push = p; v.evt = e; v.err = er;
        vecs.push_back(v);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge CLOCK_50); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge CLOCK_50); #1;
        rx_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done = 0;
        evt_ready = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge CLOCK_50);
            if (sb.size() == 0 && !evt_valid) done = 1;
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    // Scoreboard: every accepted head event must match the oldest expected one
    always @(negedge CLOCK_50) begin
        if (!reset && evt_valid && evt_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_evt", {22'd0, evt_break, evt_ext, evt_code}, 32'h3FF_FFFF);
            end else begin
                logic [9:0] exp;
                exp = sb.pop_front();
                chk("evt_head", {22'd0, evt_break, evt_ext, evt_code}, {22'd0, exp});
            end
        end
    end

    initial begin
        int first;
        reset        = 1'b1;
        rx_data      = 8'h00;
        rx_valid     = 1'b0;
        evt_ready    = 1'b1;
        clr_overflow = 1'b0;

        // Byte-by-byte table: {byte, event expected, event {brk,ext,code}, error expected}
        add_v(8'h1C, 1, {2'b00, 8'h1C}, 0);
        add_v(8'hF0, 0, 10'h0,          0);
        add_v(8'h1C, 1, {2'b10, 8'h1C}, 0);
        add_v(8'hE0, 0, 10'h0,          0);
        add_v(8'h75, 1, {2'b01, 8'h75}, 0);
        add_v(8'hE0, 0, 10'h0,          0);
        add_v(8'hF0, 0, 10'h0,          0);
        add_v(8'h75, 1, {2'b11, 8'h75}, 0);
        add_v(8'hE0, 0, 10'h0,          0);
        add_v(8'hE0, 0, 10'h0,          0);
        add_v(8'h75, 1, {2'b01, 8'h75}, 0);
        add_v(8'hE1, 0, 10'h0,          0);
        add_v(8'h14, 0, 10'h0,          0);
        add_v(8'h77, 0, 10'h0,          0);
        add_v(8'hE1, 0, 10'h0,          0);
        add_v(8'hF0, 0, 10'h0,          0);
        add_v(8'h14, 0, 10'h0,          0);
        add_v(8'hF0, 0, 10'h0,          0);
        add_v(8'h77, 1, {2'b01, 8'hE1}, 0);
        add_v(8'hFA, 0, 10'h0,          0);
        add_v(8'hAA, 0, 10'h0,          0);
        add_v(8'h00, 0, 10'h0,          0);
        add_v(8'hF0, 0, 10'h0,          0);
        add_v(8'hF0, 0, 10'h0,          1);
        add_v(8'hE0, 0, 10'h0,          0);
        add_v(8'hFA, 0, 10'h0,          1);
        add_v(8'hF0, 0, 10'h0,          0);
        add_v(8'hE0, 0, 10'h0,          1);
        add_v(8'hE0, 0, 10'h0,          0);
        add_v(8'hF0, 0, 10'h0,          0);
        add_v(8'hE1, 0, 10'h0,          1);
        add_v(8'h5A, 1, {2'b00, 8'h5A}, 0);

        repeat (3) @(posedge CLOCK_50);
        #1 reset = 1'b0;
        @(negedge CLOCK_50);
        chk("rst_valid",    {31'd0, evt_valid}, 32'd0);
        chk("rst_evt",      {22'd0, evt_break, evt_ext, evt_code}, 32'd0);
        chk("rst_count",    32'(fifo_count), 32'd0);
        chk("rst_overflow", {31'd0, overflow},  32'd0);
        chk("rst_seq_err",  {31'd0, seq_error}, 32'd0);

        // Table sweep with consumer always ready
        foreach (vecs[i]) begin
            if (vecs[i].push) sb.push_back(vecs[i].evt);
            send_byte(vecs[i].b);
            @(negedge CLOCK_50);
            chk($sformatf("vec%0d_seq_err", i), {31'd0, seq_error}, {31'd0, vecs[i].err});
            chk($sformatf("vec%0d_latency", i), {31'd0, evt_valid}, {31'd0, vecs[i].push});
        end
        drain("table_drain");

        // Fill the FIFO with nine make codes while stalled
        evt_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            logic [7:0] c;
            c = 8'h10 + 8'(i);
            if (i < DEPTH) sb.push_back({2'b00, c});
            send_byte(c);
        end
        @(negedge CLOCK_50);
        chk("full_count",    32'(fifo_count), DEPTH);
        chk("full_overflow", {31'd0, overflow}, 32'd1);
        chk("full_head",     {24'd0, evt_code}, 32'h10);
        chk("full_valid",    {31'd0, evt_valid}, 32'd1);

        @(posedge CLOCK_50); #1 clr_overflow = 1'b1;
        @(posedge CLOCK_50); #1 clr_overflow = 1'b0;
        @(negedge CLOCK_50);
        chk("clr_overflow", {31'd0, overflow}, 32'd0);

        // Full with push and pop together
        sb.push_back({2'b00, 8'h30});
        @(posedge CLOCK_50); #1;
        rx_data = 8'h30; rx_valid = 1'b1; evt_ready = 1'b1;
        @(posedge CLOCK_50); #1;
        rx_valid = 1'b0; evt_ready = 1'b0;
        @(negedge CLOCK_50);
        chk("pushpop_count",    32'(fifo_count), DEPTH);
        chk("pushpop_overflow", {31'd0, overflow}, 32'd0);
        chk("pushpop_head",     {24'd0, evt_code}, 32'h11);

        // Overflow set and clear in the same cycle: set wins
        @(posedge CLOCK_50); #1;
        rx_data = 8'h31; rx_valid = 1'b1; clr_overflow = 1'b1;
        @(posedge CLOCK_50); #1;
        rx_valid = 1'b0; clr_overflow = 1'b0;
        @(negedge CLOCK_50);
        chk("set_wins_overflow", {31'd0, overflow}, 32'd1);
        chk("set_wins_count",    32'(fifo_count), DEPTH);

        drain("overflow_drain");
        chk("drained_count", 32'(fifo_count), 32'd0);
        chk("drained_hold",  {22'd0, evt_break, evt_ext, evt_code}, 32'h030);

        // Idle timeout after a lone break prefix
        send_byte(8'hF0);
        first = -1;
        for (int i = 1; i <= 3 * TMO && first < 0; i++) begin
            @(negedge CLOCK_50);
            if (seq_error) first = i;
        end
        chk("timeout_cycle", 32'(first), TMO + 1);
        @(negedge CLOCK_50);
        chk("timeout_pulse", {31'd0, seq_error}, 32'd0);
        chk("timeout_noevt", {31'd0, evt_valid}, 32'd0);
        sb.push_back({2'b00, 8'h1C});
        send_byte(8'h1C);
        @(negedge CLOCK_50);
        chk("after_timeout_valid", {31'd0, evt_valid}, 32'd1);
        drain("timeout_drain");

        // Byte landing on the expiry cycle is processed instead of timing out
        send_byte(8'hF0);
        repeat (TMO - 2) @(posedge CLOCK_50);
        sb.push_back({2'b10, 8'h1C});
        send_byte(8'h1C);
        @(negedge CLOCK_50);
        chk("expiry_race_err",   {31'd0, seq_error}, 32'd0);
        chk("expiry_race_valid", {31'd0, evt_valid}, 32'd1);
        drain("race_drain");

        // Reset mid-sequence with events queued
        evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] c;
            c = 8'h20 + 8'(i);
            send_byte(c);
        end
        send_byte(8'hE0);
        @(posedge CLOCK_50); #1 reset = 1'b1;
        @(posedge CLOCK_50); #1 reset = 1'b0;
        sb.delete();
        @(negedge CLOCK_50);
        chk("midrst_valid", {31'd0, evt_valid}, 32'd0);
        chk("midrst_count", 32'(fifo_count), 32'd0);
        chk("midrst_code",  {24'd0, evt_code}, 32'd0);
        evt_ready = 1'b1;
        sb.push_back({2'b00, 8'h75});
        send_byte(8'h75);
        @(negedge CLOCK_50);
        chk("midrst_next_valid", {31'd0, evt_valid}, 32'd1);
        drain("final_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
